shadow_copy_controller: RTL



---
 rtl/shadow_copy_controller.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/shadow_copy_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : shadow_copy_controller                                           |
// | Purpose : Boot-time ROM-to-shadow-RAM copy sequencer. Holds the CPU in     |
// |           reset and owns the memory bus until the image is valid.          |
// | Option  : SHADOW_VERIFY_EN adds a ROM/RAM read-back verify pass.           |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module shadow_copy_controller #(
   parameter logic [15:0] COPY_LAST = 16'hFFFF,
   parameter int unsigned ROM_WAIT  = 1
) (
   input  logic        CopyClock,
   input  logic        Reset,
   input  logic        ResetReq,
   input  logic [15:0] RomData,
`ifdef SHADOW_VERIFY_EN
   input  logic [15:0] RamData,
   output logic        RamOE,
   output logic        VerifyErr,
`endif
   output logic [15:0] CopyAddr,
   output logic [15:0] CopyData,
   output logic        RomOE,
   output logic        RamWE,
   output logic        CopyBusEn,
   output logic        CpuReset,
   output logic        CopyDone,
   output logic [16:0] CopyCount
);

   typedef enum logic [3:0] {
      S_START   = 4'd0,
      S_READ    = 4'd1,
      S_WAIT    = 4'd2,
      S_CAPTURE = 4'd3,
      S_WRITE   = 4'd4,
      S_DONE    = 4'd5,
      S_VROM    = 4'd6,
      S_VROMCAP = 4'd7,
      S_VRAM    = 4'd8,
      S_VRAMCMP = 4'd9
   } state_t;

   localparam logic [2:0] c_WAIT_LAST = (ROM_WAIT > 0) ? 3'(ROM_WAIT - 1) : 3'd0;
`ifdef SHADOW_VERIFY_EN
   // Verify read strobes stay up for the select cycle plus the ROM wait cycles.
   localparam logic [2:0] c_RD_LAST   = 3'(ROM_WAIT);
`endif

   state_t      state_q;
   logic [15:0] addr_q;
   logic [15:0] data_q;
   logic [16:0] count_q;
   logic [2:0]  wait_q;
   logic        rom_oe_q;
   logic        ram_we_q;
   logic        bus_en_q;
   logic        cpu_reset_q;
   logic        done_q;
`ifdef SHADOW_VERIFY_EN
   logic        ram_oe_q;
   logic        verify_err_q;
`endif

   always_ff @(posedge CopyClock or posedge Reset) begin
      if (Reset) begin
         state_q     <= S_START;
         addr_q      <= 16'd0;
         data_q      <= 16'd0;
         count_q     <= 17'd0;
         wait_q      <= 3'd0;
         rom_oe_q    <= 1'b0;
         ram_we_q    <= 1'b0;
         bus_en_q    <= 1'b1;
         cpu_reset_q <= 1'b1;
         done_q      <= 1'b0;
`ifdef SHADOW_VERIFY_EN
         ram_oe_q     <= 1'b0;
         verify_err_q <= 1'b0;
`endif
      end else if (ResetReq) begin
         // Warm restart wins over any state, aborting an in-flight write.
         state_q     <= S_START;
         addr_q      <= 16'd0;
         count_q     <= 17'd0;
         wait_q      <= 3'd0;
         rom_oe_q    <= 1'b0;
         ram_we_q    <= 1'b0;
         bus_en_q    <= 1'b1;
         cpu_reset_q <= 1'b1;
         done_q      <= 1'b0;
`ifdef SHADOW_VERIFY_EN
         ram_oe_q     <= 1'b0;
         verify_err_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_START: begin
               addr_q   <= 16'd0;
               count_q  <= 17'd0;
               done_q   <= 1'b0;
               rom_oe_q <= 1'b1;
               state_q  <= S_READ;
            end
            S_READ: begin
               wait_q  <= 3'd0;
               state_q <= (ROM_WAIT == 0) ? S_CAPTURE : S_WAIT;
            end
            S_WAIT: begin
               if (wait_q == c_WAIT_LAST) begin
                  state_q <= S_CAPTURE;
               end else begin
                  wait_q <= wait_q + 3'd1;
               end
            end
            S_CAPTURE: begin
               data_q   <= RomData;
               rom_oe_q <= 1'b0;
               ram_we_q <= 1'b1;
               state_q  <= S_WRITE;
            end
            S_WRITE: begin
               ram_we_q <= 1'b0;
               count_q  <= count_q + 17'd1;
               if (addr_q == COPY_LAST) begin
`ifdef SHADOW_VERIFY_EN
                  addr_q   <= 16'd0;
                  wait_q   <= 3'd0;
                  rom_oe_q <= 1'b1;
                  state_q  <= S_VROM;
`else
                  done_q      <= 1'b1;
                  bus_en_q    <= 1'b0;
                  cpu_reset_q <= 1'b0;
                  state_q     <= S_DONE;
`endif
               end else begin
                  addr_q   <= addr_q + 16'd1;
                  rom_oe_q <= 1'b1;
                  state_q  <= S_READ;
               end
            end
            S_DONE: begin
               state_q <= S_DONE;
            end
`ifdef SHADOW_VERIFY_EN
            S_VROM: begin
               if (wait_q == c_RD_LAST) begin
                  state_q <= S_VROMCAP;
               end else begin
                  wait_q <= wait_q + 3'd1;
               end
            end
            S_VROMCAP: begin
               data_q   <= RomData;
               rom_oe_q <= 1'b0;
               ram_oe_q <= 1'b1;
               wait_q   <= 3'd0;
               state_q  <= S_VRAM;
            end
            S_VRAM: begin
               if (wait_q == c_RD_LAST) begin
                  state_q <= S_VRAMCMP;
               end else begin
                  wait_q <= wait_q + 3'd1;
               end
            end
            S_VRAMCMP: begin
               ram_oe_q <= 1'b0;
               if (RamData != data_q) begin
                  // A bad image leaves the CPU parked in reset.
                  verify_err_q <= 1'b1;
                  done_q       <= 1'b1;
                  bus_en_q     <= 1'b0;
                  state_q      <= S_DONE;
               end else if (addr_q == COPY_LAST) begin
                  done_q      <= 1'b1;
                  bus_en_q    <= 1'b0;
                  cpu_reset_q <= 1'b0;
                  state_q     <= S_DONE;
               end else begin
                  addr_q   <= addr_q + 16'd1;
                  wait_q   <= 3'd0;
                  rom_oe_q <= 1'b1;
                  state_q  <= S_VROM;
               end
            end
`endif
            default: begin
               state_q <= S_START;
            end
         endcase
      end
   end

   assign CopyAddr  = addr_q;
   assign CopyData  = data_q;
   assign RomOE     = rom_oe_q;
   assign RamWE     = ram_we_q;
   assign CopyBusEn = bus_en_q;
   assign CpuReset  = cpu_reset_q;
   assign CopyDone  = done_q;
   assign CopyCount = count_q;
`ifdef SHADOW_VERIFY_EN
   assign RamOE     = ram_oe_q;
   assign VerifyErr = verify_err_q;
`endif

endmodule
`default_nettype wire
